// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the clock-setting controller and its surroundings:
// buttons and live time in, run/load strobes, edited time and display blanking out.
interface clock_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic       run_en;
  logic       load;
  logic [5:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic [2:0] blink_mask;
  logic [1:0] state;

  modport master (
    output btn_mode, btn_inc, cur_hours, cur_minutes, cur_seconds,
    input  run_en, load, set_hours, set_minutes, set_seconds, blink_mask, state
  );

  modport slave (
    input  btn_mode, btn_inc, cur_hours, cur_minutes, cur_seconds,
    output run_en, load, set_hours, set_minutes, set_seconds, blink_mask, state
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode button steps RUN -> hours -> minutes -> seconds -> RUN,
// inc button bumps the selected field, the field being edited blinks, idle edits are abandoned.
module clock_set_ctrl #(
  parameter int unsigned BLINK_DIV = 12500000,
  parameter int unsigned TIMEOUT   = 500000000
) (
  input  logic            clk,
  input  logic            rst,
  clock_set_ctrl_if.slave bus
);

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, inc_q;
  logic [5:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          run_en_q, run_en_d;
  logic          load_q, load_d;
  logic [2:0]    mask_q, mask_d;

  logic mode_press, inc_press, inc_accept, state_chg;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] limit);
    return (v < limit) ? v : 6'd0;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    mode_press  = bus.btn_mode & ~mode_q;
    inc_press   = bus.btn_inc & ~inc_q;
    state_d     = state_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    load_d      = 1'b0;
    inc_accept  = 1'b0;

    // Mode beats inc when both press in the same cycle; timeout only when no press.
    case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d   = SET_H;
          hours_d   = clamp(bus.cur_hours, 6'd24);
          minutes_d = clamp(bus.cur_minutes, 6'd60);
          seconds_d = clamp(bus.cur_seconds, 6'd60);
        end
      end
      SET_H: begin
        if (mode_press) state_d = SET_M;
        else if (inc_press) begin
          hours_d    = wrap_inc(hours_q, 6'd23);
          inc_accept = 1'b1;
        end else if (idle_q == IDLE_LAST) state_d = RUN;
      end
      SET_M: begin
        if (mode_press) state_d = SET_S;
        else if (inc_press) begin
          minutes_d  = wrap_inc(minutes_q, 6'd59);
          inc_accept = 1'b1;
        end else if (idle_q == IDLE_LAST) state_d = RUN;
      end
      SET_S: begin
        if (mode_press) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (inc_press) begin
          seconds_d  = wrap_inc(seconds_q, 6'd59);
          inc_accept = 1'b1;
        end else if (idle_q == IDLE_LAST) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    state_chg = (state_d != state_q);

    if (state_d == RUN || state_chg || inc_accept) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      phase_d     = phase_q;
    end

    if (state_d == RUN || state_chg || mode_press || inc_press) idle_d = '0;
    else                                                       idle_d = idle_q + IW'(1);

    run_en_d = (state_d == RUN);

    case (state_d)
      SET_H:   mask_d = {phase_d, 2'b00};
      SET_M:   mask_d = {1'b0, phase_d, 1'b0};
      SET_S:   mask_d = {2'b00, phase_d};
      default: mask_d = 3'b000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      // Samples start at 1 so a button held through reset never looks like a fresh press.
      mode_q      <= 1'b1;
      inc_q       <= 1'b1;
      hours_q     <= '0;
      minutes_q   <= '0;
      seconds_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      idle_q      <= '0;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      mask_q      <= 3'b000;
    end else begin
      state_q     <= state_d;
      mode_q      <= bus.btn_mode;
      inc_q       <= bus.btn_inc;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      idle_q      <= idle_d;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      mask_q      <= mask_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.run_en      = run_en_q;
  assign bus.load        = load_q;
  assign bus.set_hours   = hours_q;
  assign bus.set_minutes = minutes_q;
  assign bus.set_seconds = seconds_q;
  assign bus.blink_mask  = mask_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button traffic, every cycle
// compared against a behavioural model built on "cycles since last event" ages.
module tb_clock_set_ctrl;
  localparam int BLINK_DIV = 4;
  localparam int TIMEOUT   = 50;

  logic clk = 1'b0;
  logic rst;

  clock_set_ctrl_if ifc ();

  clock_set_ctrl #(.BLINK_DIV(BLINK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int load_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=run,1=hours,2=minutes,3=seconds; ages count cycles since the last restart.
  int m_mode, m_h, m_m, m_s, m_age, m_idle;
  bit m_load, m_prev_mode, m_prev_inc;

  task automatic model_step();
    bit mp, ip;
    int old;
    if (rst) begin
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0;
      m_age = 0; m_idle = 0; m_load = 0;
      m_prev_mode = 1; m_prev_inc = 1;
      return;
    end
    mp = ifc.btn_mode && !m_prev_mode;
    ip = ifc.btn_inc && !m_prev_inc;
    m_prev_mode = ifc.btn_mode;
    m_prev_inc  = ifc.btn_inc;
    old = m_mode;
    m_load = 0;
    if (old == 0) begin
      if (mp) begin
        m_mode = 1;
        m_h = (int'(ifc.cur_hours) < 24) ? int'(ifc.cur_hours) : 0;
        m_m = (int'(ifc.cur_minutes) < 60) ? int'(ifc.cur_minutes) : 0;
        m_s = (int'(ifc.cur_seconds) < 60) ? int'(ifc.cur_seconds) : 0;
      end
    end else if (mp) begin
      m_mode = (old + 1) % 4;
      m_load = (m_mode == 0);
    end else if (ip) begin
      case (old)
        1:       m_h = (m_h + 1) % 24;
        2:       m_m = (m_m + 1) % 60;
        default: m_s = (m_s + 1) % 60;
      endcase
    end else if (m_idle == TIMEOUT - 1) begin
      m_mode = 0;
    end
    if (m_mode == 0 || m_mode != old || (ip && !mp)) m_age = 0;
    else m_age++;
    if (m_mode == 0 || m_mode != old || mp || ip) m_idle = 0;
    else m_idle++;
  endtask

  function automatic logic [2:0] exp_mask();
    logic ph;
    ph = ((m_age / BLINK_DIV) % 2) == 1;
    case (m_mode)
      1:       return {ph, 2'b00};
      2:       return {1'b0, ph, 1'b0};
      3:       return {2'b00, ph};
      default: return 3'b000;
    endcase
  endfunction

  task automatic compare_all();
    logic [17:0] t;
    t = {m_h[5:0], m_m[5:0], m_s[5:0]};
    check("state", 32'(ifc.state), 32'(m_mode));
    check("run_en", 32'(ifc.run_en), 32'(m_mode == 0));
    check("load", 32'(ifc.load), 32'(m_load));
    check("set_time", 32'({ifc.set_hours, ifc.set_minutes, ifc.set_seconds}), 32'(t));
    check("blink_mask", 32'(ifc.blink_mask), 32'(exp_mask()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (ifc.load === 1'b1) load_seen++;
  endtask

  task automatic press(input bit m, input bit i);
    ifc.btn_mode = m;
    ifc.btn_inc  = i;
    tick();
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    tick();
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    ifc.cur_hours   = 6'(h);
    ifc.cur_minutes = 6'(m);
    ifc.cur_seconds = 6'(s);
  endtask

  function automatic logic [31:0] cur_set();
    return 32'({ifc.set_hours, ifc.set_minutes, ifc.set_seconds});
  endfunction

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    logic [5:0] a, b, c;
    a = 6'(h); b = 6'(m); c = 6'(s);
    return 32'({a, b, c});
  endfunction

  initial begin
    int mode_rate, inc_rate;
    rst = 1'b1;
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    set_cur(0, 0, 0);
    repeat (2) tick();
    check("rst_outputs", 32'({ifc.state, ifc.run_en, ifc.load, ifc.blink_mask}), 32'(7'b00_1_0_000));
    check("rst_time", cur_set(), 32'd0);
    rst = 1'b0;
    tick();

    // Capture 12:34:56, then walk the three set states and commit.
    set_cur(12, 34, 56);
    press(1, 0);
    check("capture_state", 32'(ifc.state), 32'd1);
    check("capture_time", cur_set(), hms(12, 34, 56));
    check("capture_run_en", 32'(ifc.run_en), 32'd0);
    load_seen = 0;
    press(1, 0);
    press(1, 0);
    press(1, 0);
    repeat (3) tick();
    check("commit_load_cycles", 32'(load_seen), 32'd1);
    check("commit_state", 32'(ifc.state), 32'd0);
    check("commit_run_en", 32'(ifc.run_en), 32'd1);

    // Hours 22 -> 23 -> 0, minutes 58 -> 59 -> 0.
    set_cur(22, 58, 0);
    press(1, 0);
    press(0, 1);
    check("hours_inc", 32'(ifc.set_hours), 32'd23);
    press(0, 1);
    check("hours_wrap", 32'(ifc.set_hours), 32'd0);
    press(1, 0);
    press(0, 1);
    check("minutes_inc", 32'(ifc.set_minutes), 32'd59);
    press(0, 1);
    check("minutes_wrap", 32'(ifc.set_minutes), 32'd0);
    press(1, 0);
    press(1, 0);

    // Blink in SET_M: 000 for 4 cycles, 010 for 4 cycles, restarted by an inc press.
    press(1, 0);
    ifc.btn_mode = 1'b1;
    tick();
    ifc.btn_mode = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("blink_idle", 32'(ifc.blink_mask), ((i / 4) % 2 == 1) ? 32'd2 : 32'd0);
      tick();
    end
    check("blink_before_inc", 32'(ifc.blink_mask), 32'd2);
    ifc.btn_inc = 1'b1;
    tick();
    ifc.btn_inc = 1'b0;
    check("blink_restart", 32'(ifc.blink_mask), 32'd0);
    tick();
    press(1, 0);
    press(1, 0);

    // Held inc gives one step; simultaneous mode+inc in SET_S commits without incrementing.
    set_cur(22, 58, 7);
    press(1, 0);
    ifc.btn_inc = 1'b1;
    repeat (10) tick();
    ifc.btn_inc = 1'b0;
    tick();
    check("held_inc", 32'(ifc.set_hours), 32'd23);
    press(1, 0);
    press(1, 0);
    ifc.btn_mode = 1'b1;
    ifc.btn_inc  = 1'b1;
    tick();
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    check("both_state", 32'(ifc.state), 32'd0);
    check("both_load", 32'(ifc.load), 32'd1);
    check("both_time", cur_set(), hms(23, 58, 7));
    tick();

    // Timeout from SET_H after exactly TIMEOUT idle cycles, no load.
    set_cur(5, 6, 7);
    ifc.btn_mode = 1'b1;
    tick();
    ifc.btn_mode = 1'b0;
    load_seen = 0;
    repeat (TIMEOUT - 1) tick();
    check("timeout_not_yet", 32'(ifc.state), 32'd1);
    tick();
    check("timeout_state", 32'(ifc.state), 32'd0);
    check("timeout_run_en", 32'(ifc.run_en), 32'd1);
    check("timeout_no_load", 32'(load_seen), 32'd0);
    check("timeout_time", cur_set(), hms(5, 6, 7));

    // Reset in the middle of SET_M abandons the edit.
    press(1, 0);
    press(1, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_state", 32'(ifc.state), 32'd0);
    check("midrst_time", cur_set(), 32'd0);
    check("midrst_load", 32'(ifc.load), 32'd0);
    rst = 1'b0;
    tick();

    // Out-of-range capture, and mode held through reset release.
    set_cur(30, 61, 59);
    press(1, 0);
    check("capture_clamp", cur_set(), hms(0, 0, 59));
    rst = 1'b1;
    ifc.btn_mode = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("held_through_rst", 32'(ifc.state), 32'd0);
    ifc.btn_mode = 1'b0;
    tick();

    // Random traffic with per-segment button activity so timeouts also occur.
    mode_rate = 8;
    inc_rate  = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        mode_rate = $urandom_range(4, 120);
        inc_rate  = $urandom_range(2, 200);
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, mode_rate) == 0) ifc.btn_mode = ~ifc.btn_mode;
      if ($urandom_range(0, inc_rate) == 0) ifc.btn_inc = ~ifc.btn_inc;
      if ($urandom_range(0, 7) == 0)
        set_cur($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
